// File: rtl/i2c_slave_core.sv
`timescale 1ns/1ps
// i2c_slave_core: 7-bit-address I2C slave front end with a byte-wide
// register file. The master writes a register pointer and then data bytes,
// or reads bytes back from the current pointer.
// Optional feature: define I2C_SLAVE_AUTO_INC_EN to advance the pointer after
// every transferred byte; otherwise the pointer stays fixed for a transaction.
module i2c_slave_core #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned NUM_REGS   = 16,
  localparam int unsigned PTR_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  // Next pointer value after a transferred byte; wraps at the top register.
  function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p);
`ifdef I2C_SLAVE_AUTO_INC_EN
    return (p == PTR_W'(NUM_REGS - 1)) ? '0 : p + 1'b1;
`else
    return p;
`endif
  endfunction

  // Bus sampling
  logic [1:0] scl_sync, sda_sync;
  logic       scl_q, sda_q;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // Protocol state
  state_t           state, state_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  logic             rw, rw_n;
  logic             ack_on, ack_on_n;
  logic             sda_oe_n, busy_n;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr_n;
  logic [7:0]       wr_data_n;
  logic [7:0]       rx_byte, rd_byte;
  logic [7:0]       regs [NUM_REGS];

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  // Edges are taken from the synchronized copies; START/STOP additionally
  // require SCL to have been high on both sides of the SDA transition.
  assign scl_rise  =  scl_s & ~scl_q;
  assign scl_fall  = ~scl_s &  scl_q;
  assign start_det =  scl_s &  scl_q &  sda_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_q & ~sda_q &  sda_s;

  assign rx_byte = {shift[6:0], sda_s};
  assign rd_byte = regs[ptr];

  // Two-flop synchronizers plus one delay stage for edge detection; an idle
  // bus reads high, so everything resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value, which is what makes this a real shift chain.
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      ack_on  <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      ptr     <= ptr_n;
      rw      <= rw_n;
      ack_on  <= ack_on_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      wr_stb  <= wr_en;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  // Register file; contents survive STOP and only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is reset on purpose (registers must read 0 after
      // reset), which keeps it in flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else if (wr_en) begin
      regs[wr_addr_n] <= wr_data_n;
    end
  end

  // Next-state and output logic. Received bits are taken on SCL rising,
  // SDA is only ever changed on SCL falling.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    ptr_n     = ptr;
    rw_n      = rw;
    ack_on_n  = ack_on;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    wr_en     = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;

    if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
      ack_on_n = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      ack_on_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;

        ADDR: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              state_n  = ADDR_ACK;
              busy_n   = 1'b1;
              rw_n     = rx_byte[0];
              ack_on_n = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end
        end

        // First falling edge pulls SDA for the ACK, second one ends it.
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_on) begin
            sda_oe_n = 1'b1;
            ack_on_n = 1'b1;
          end else begin
            ack_on_n = 1'b0;
            if (state == WR_ACK) begin
              sda_oe_n = 1'b0;
              state_n  = WR_DATA;
            end else if (!rw) begin
              sda_oe_n = 1'b0;
              state_n  = PTR;
            end else begin
              sda_oe_n = ~rd_byte[7];
              shift_n  = {rd_byte[6:0], 1'b0};
              state_n  = RD_DATA;
            end
          end
        end

        PTR: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ptr_n    = PTR_W'(32'(rx_byte) % NUM_REGS);
            ack_on_n = 1'b0;
            state_n  = WR_ACK;
          end
        end

        WR_DATA: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            wr_en     = 1'b1;
            wr_addr_n = ptr;
            wr_data_n = rx_byte;
            ptr_n     = ptr_adv(ptr);
            ack_on_n  = 1'b0;
            state_n   = WR_ACK;
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            sda_oe_n = ~shift[7];
            shift_n  = {shift[6:0], 1'b0};
          end else if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_on_n = 1'b0;
              state_n  = RD_ACK;
            end
          end
        end

        // ack_on here means "master ACKed, next byte loaded, drive its MSB".
        RD_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_oe_n = 1'b0;
            end else begin
              sda_oe_n = ~shift[7];
              shift_n  = {shift[6:0], 1'b0};
              ack_on_n = 1'b0;
              state_n  = RD_DATA;
            end
          end else if (scl_rise) begin
            if (!sda_s) begin
              ptr_n    = ptr_adv(ptr);
              shift_n  = regs[ptr_adv(ptr)];
              ack_on_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = IDLE;
            end
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_core.sv
`timescale 1ns/1ps
// tb_i2c_slave_core: bit-banged I2C master against a transaction-level model
// of the register file (pointer + array), with random write/read traffic.
module tb_i2c_slave_core;

  localparam int NREGS = 16;
  localparam int Q     = 12;   // clk cycles per quarter of an SCL bit slot
`ifdef I2C_SLAVE_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: register array and pointer.
  logic [7:0] ref_regs [NREGS];
  int         ref_ptr;

  // Bus monitors.
  logic [11:0] stb_log [1024];
  int          stb_n    = 0;
  int          oe_cnt   = 0;
  int          busy_cnt = 0;

  logic [7:0] txq [$];

  assign sda_line = sda_m & ~sda_oe;   // open-drain wired-AND

  i2c_slave_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl     (scl_m),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_log[stb_n % 1024] = {wr_addr, wr_data};
      stb_n++;
    end
    if (sda_oe) oe_cnt++;
    if (busy)   busy_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  // START from idle bus, or repeated START from SCL low.
  task automatic bus_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic write_byte(input logic [7:0] b, output bit acked);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; q();
      scl_m = 1'b1; q();
      scl_m = 1'b0; q();
    end
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    acked = (sda_line == 1'b0);
    scl_m = 1'b0; q();
  endtask

  task automatic read_byte(input bit nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q();
      scl_m = 1'b1; q();
      b[i] = sda_line;
      scl_m = 1'b0; q();
    end
    sda_m = nack; q();
    scl_m = 1'b1; q();
    scl_m = 1'b0; q();
  endtask

  // START, address+W, pointer, txq data bytes, STOP; checks ACKs and strobes.
  task automatic write_txn(input logic [7:0] p);
    bit          a;
    int          base;
    logic [11:0] exp_stb [$];
    base = stb_n;
    bus_start();
    write_byte(8'hA0, a);  check("addr_w_ack", a, 1);
    check("busy_after_match", busy, 1);
    write_byte(p, a);      check("ptr_ack", a, 1);
    ref_ptr = p % NREGS;
    foreach (txq[i]) begin
      write_byte(txq[i], a);
      check("data_ack", a, 1);
      ref_regs[ref_ptr] = txq[i];
      exp_stb.push_back({4'(ref_ptr), txq[i]});
      if (AUTO) ref_ptr = (ref_ptr + 1) % NREGS;
    end
    bus_stop();
    check("busy_after_stop", busy, 0);
    check("stb_count", stb_n - base, exp_stb.size());
    foreach (exp_stb[i]) check("stb_addr_data", stb_log[(base + i) % 1024], exp_stb[i]);
  endtask

  // Pointer write, repeated START, read n bytes (ACK all but the last), STOP.
  task automatic read_txn(input logic [7:0] p, input int n);
    bit         a;
    int         base;
    logic [7:0] b;
    base = stb_n;
    bus_start();
    write_byte(8'hA0, a); check("rd_addr_w_ack", a, 1);
    write_byte(p, a);     check("rd_ptr_ack", a, 1);
    ref_ptr = p % NREGS;
    bus_start();
    write_byte(8'hA1, a); check("addr_r_ack", a, 1);
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, b);
      check("read_data", b, ref_regs[ref_ptr]);
      if (k != n - 1 && AUTO) ref_ptr = (ref_ptr + 1) % NREGS;
    end
    bus_stop();
    check("rd_busy_after_stop", busy, 0);
    check("rd_no_stb", stb_n - base, 0);
  endtask

  initial begin
    bit   a;
    int   oe0, busy0, stb0;
    for (int i = 0; i < NREGS; i++) ref_regs[i] = 8'h00;
    ref_ptr = 0;

    // Reset values.
    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    q();

    // Single write then read back through repeated START.
    txq = '{8'h5A};
    write_txn(8'h03);
    read_txn(8'h03, 1);

    // Foreign address: no ACK, no busy, no write.
    oe0 = oe_cnt; busy0 = busy_cnt; stb0 = stb_n;
    bus_start();
    write_byte(8'hA2, a); check("foreign_addr_nack", a, 0);
    write_byte(8'h33, a); check("foreign_data_nack", a, 0);
    bus_stop();
    check("foreign_oe_never", oe_cnt - oe0, 0);
    check("foreign_busy_never", busy_cnt - busy0, 0);
    check("foreign_no_stb", stb_n - stb0, 0);

    // Pointer wrap at the top register.
    txq = '{8'h11, 8'h22};
    write_txn(8'h0F);
    read_txn(8'h0F, 1);
    read_txn(8'h00, 1);

    // Burst write and burst read.
    txq = '{8'h01, 8'h02, 8'h03};
    write_txn(8'h00);
    read_txn(8'h00, 3);

    // Random traffic, including pointer bytes beyond NUM_REGS.
    for (int it = 0; it < 6; it++) begin
      int n;
      txq.delete();
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) txq.push_back(8'($urandom));
      write_txn(8'($urandom));
      read_txn(8'($urandom_range(0, 255)), $urandom_range(1, 3));
    end

    // Reset while the slave is driving a read bit low.
    txq = '{8'h12};
    write_txn(8'h05);
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h05, a);
    bus_start();
    write_byte(8'hA1, a); check("rst_test_addr_ack", a, 1);
    check("rd_msb_driven", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_sda_oe", sda_oe, 0);
    check("async_rst_busy", busy, 0);
    for (int i = 0; i < NREGS; i++) ref_regs[i] = 8'h00;
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    rst_n = 1'b1; q();
    // Without a new START the slave must ignore a well-formed address byte.
    write_byte(8'hA0, a); check("no_start_ignored", a, 0);
    check("no_start_busy", busy, 0);
    bus_stop();
    read_txn(8'h05, 1);
    read_txn(8'h0F, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
